as5311_emu: RTL and testbench

//   SSI responder emulating one AS5311 encoder on the FPGA side of the link. Driven by the

---
 rtl/as5311_emu_pkg.sv | 40 ++++
 rtl/as5311_emu_if.sv | 17 +
 rtl/as5311_emu_pin_sync.sv | 38 +++
 rtl/as5311_emu.sv | 160 ++++++++++++++++
 tb/tb_as5311_emu.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/as5311_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : as5311_pkg
// Brief    : Shared constants, state encoding and frame builder for the
//            AS5311 SSI emulator and its reader counterpart.
// Revision : 1.0
// ============================================================================
package as5311_pkg;

   localparam int BITSIZE   = 18;
   localparam int DATA_BITS = 12;
   localparam int STAT_BITS = 6;

   // Bit positions inside the 5-bit stat_in vector (PAR is computed, not input)
   localparam int ST_OCF    = 4;
   localparam int ST_COF    = 3;
   localparam int ST_LIN    = 2;
   localparam int ST_MAGINC = 1;
   localparam int ST_MAGDEC = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Frame-type encodings shared with the reader
   localparam logic FT_POS = 1'b1;
   localparam logic FT_MAG = 1'b0;

   // Build {value, status, PAR}; PAR makes the total number of ones even
   function automatic logic [BITSIZE-1:0] build_frame(
      input logic [DATA_BITS-1:0] value,
      input logic [STAT_BITS-2:0] stat
   );
      return {value, stat, ^{value, stat}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/as5311_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : as5311_emu_if
// Brief    : Three-wire SSI link between sensor master and encoder emulator.
// Revision : 1.0
// ============================================================================
interface as5311_emu_if;

   logic ssi_clk;   // master clock, idles high
   logic ssi_cs;    // chip select, active low
   logic ssi_do;    // serial data towards the master

   modport master (output ssi_clk, output ssi_cs, input ssi_do);
   modport slave  (input ssi_clk, input ssi_cs, output ssi_do);

endinterface
`default_nettype wire

// File: rtl/as5311_emu_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : ssi_pin_sync
// Brief    : Multi-flop synchronizer for one async pin plus edge detection.
//            All flops reset to 1 because both SSI pins idle high.
// Revision : 1.0
// ============================================================================
module ssi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchronizer chain, remember last synced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/as5311_emu.sv
`default_nettype none
// ============================================================================
// Module   : as5311_emu
// Brief    : SSI responder emulating one AS5311 encoder. Snapshots position or
//            magnitude at CS fall and shifts an 18-bit frame out on DO.
// Revision : 1.0
// ============================================================================
module as5311_emu
   import as5311_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   as5311_emu_if.slave          ssi,
   input  logic [DATA_BITS-1:0] pos_in,
   input  logic [DATA_BITS-1:0] mag_in,
   input  logic [STAT_BITS-2:0] stat_in,
   output logic                 frame_done,
   output logic                 frame_abort,
   output logic                 frame_type,
   output logic [15:0]          frame_cnt
);

   localparam int c_CNT_W   = $clog2(BITSIZE + 1);
   // Cycles until the reset-loaded 1s have left the synchronizer/edge flops
   localparam int c_FLUSH   = SYNC_STAGES + 1;
   localparam int c_FLUSH_W = $clog2(c_FLUSH + 1);

   logic clk_lvl, clk_rise, clk_fall_unused;
   logic cs_lvl, cs_rise, cs_fall;

   ssi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk), .rst_n(rst_n), .pin_i(ssi.ssi_clk),
      .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall_unused)
   );

   ssi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .pin_i(ssi.ssi_cs),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   state_e               state_q, state_d;
   logic [BITSIZE-1:0]   shreg_q, shreg_d;
   logic [c_CNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic                 do_q, do_d;
   logic                 done_q, done_d;
   logic                 abort_q, abort_d;
   logic                 type_q, type_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [c_FLUSH_W-1:0] flush_q;
   logic                 armed_q;
   logic                 flushed;

   // A frame may only start once CS has been seen genuinely high after reset,
   // so a CS held low through reset cannot start a bogus frame.
   assign flushed = (flush_q == c_FLUSH_W'(c_FLUSH));

   // Post-reset flush counter and CS arming flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q <= '0;
         armed_q <= 1'b0;
      end else begin
         if (!flushed) flush_q <= flush_q + c_FLUSH_W'(1);
         armed_q <= armed_q | (flushed & cs_lvl);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; CS rise takes priority over a coincident clock rise
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall && armed_q) state_d = SHIFT;
         SHIFT: begin
            if (cs_rise)                                         state_d = IDLE;
            else if (clk_rise && bitcnt_q == c_CNT_W'(1))        state_d = DRAIN;
         end
         DRAIN:   if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output/datapath logic: frame load, bit shifting, completion pulses
   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      do_d     = do_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      type_d   = type_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (cs_fall && armed_q) begin
               type_d   = clk_lvl ? FT_POS : FT_MAG;
               shreg_d  = build_frame(clk_lvl ? pos_in : mag_in, stat_in);
               bitcnt_d = c_CNT_W'(BITSIZE);
               do_d     = 1'b0;   // leading dummy bit
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               do_d     = 1'b1;
               abort_d  = 1'b1;
               bitcnt_d = '0;
            end else if (clk_rise) begin
               do_d     = shreg_q[BITSIZE-1];
               shreg_d  = {shreg_q[BITSIZE-2:0], 1'b0};
               bitcnt_d = bitcnt_q - c_CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cs_rise) begin
               do_d   = 1'b1;
               done_d = 1'b1;
               cnt_d  = cnt_q + 16'd1;
            end else if (clk_rise) begin
               do_d = 1'b0;
            end
         end
         default: do_d = 1'b1;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
         do_q     <= 1'b1;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         type_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         do_q     <= do_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
         type_q   <= type_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ssi.ssi_do  = do_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;
   assign frame_type  = type_q;
   assign frame_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_as5311_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_as5311_emu
// Brief    : Directed self-checking bench for the AS5311 SSI emulator.
// Revision : 1.0
// ============================================================================
module tb_as5311_emu;

   localparam int H = 8;   // SSI half-period in clk cycles

   logic        clk;
   logic        rst_n;
   logic [11:0] pos_in, mag_in;
   logic [4:0]  stat_in;
   logic        frame_done, frame_abort, frame_type;
   logic [15:0] frame_cnt;

   int n_checks  = 0;
   int n_fail    = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;

   as5311_emu_if ssi_if ();

   as5311_emu #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ssi(ssi_if.slave),
      .pos_in(pos_in), .mag_in(mag_in), .stat_in(stat_in),
      .frame_done(frame_done), .frame_abort(frame_abort),
      .frame_type(frame_type), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completion pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (frame_done === 1'b1)  done_cnt++;
      if (frame_abort === 1'b1) abort_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One SSI transaction: nrises clock rises, bits captured before each fall.
   // pos_in is changed to chg_val just before rise number chg_at.
   task automatic run_frame(input logic pos_type, input int nrises, input int chg_at,
                            input logic [11:0] chg_val, output logic [17:0] word);
      word = '0;
      ssi_if.ssi_clk = pos_type;
      wait_clk(H);
      ssi_if.ssi_cs = 1'b0;
      wait_clk(H);
      check("dummy_bit", {31'd0, ssi_if.ssi_do}, 32'd0);
      ssi_if.ssi_clk = 1'b0;
      wait_clk(H);
      for (int k = 0; k < nrises; k++) begin
         if (k == chg_at) pos_in = chg_val;
         ssi_if.ssi_clk = 1'b1;
         wait_clk(H);
         word = {word[16:0], ssi_if.ssi_do};
         ssi_if.ssi_clk = 1'b0;
         wait_clk(H);
      end
      ssi_if.ssi_clk = 1'b1;
      wait_clk(H);
      ssi_if.ssi_cs = 1'b1;
      wait_clk(H);
   endtask

   initial begin
      logic [17:0] w;
      int d0, a0;

      rst_n = 1'b0;
      ssi_if.ssi_clk = 1'b1;
      ssi_if.ssi_cs  = 1'b1;
      pos_in  = 12'h000;
      mag_in  = 12'h000;
      stat_in = 5'b00000;
      wait_clk(4);

      // Reset state
      check("rst_do",    {31'd0, ssi_if.ssi_do}, 32'd1);
      check("rst_done",  {31'd0, frame_done},    32'd0);
      check("rst_abort", {31'd0, frame_abort},   32'd0);
      check("rst_type",  {31'd0, frame_type},    32'd0);
      check("rst_cnt",   {16'd0, frame_cnt},     32'd0);
      rst_n = 1'b1;
      wait_clk(10);
      check("idle_do", {31'd0, ssi_if.ssi_do}, 32'd1);

      // 1: position frame, OCF set
      pos_in = 12'hABC; stat_in = 5'b10000; d0 = done_cnt; a0 = abort_cnt;
      run_frame(1'b1, 18, -1, 12'h000, w);
      check("t1_word",  {14'd0, w},           32'h2AF20);
      check("t1_done",  done_cnt - d0,        32'd1);
      check("t1_abort", abort_cnt - a0,       32'd0);
      check("t1_cnt",   {16'd0, frame_cnt},   32'd1);
      check("t1_type",  {31'd0, frame_type},  32'd1);
      check("t1_do",    {31'd0, ssi_if.ssi_do}, 32'd1);

      // 2: magnitude frame, odd data -> PAR=1
      mag_in = 12'h001; stat_in = 5'b00000; d0 = done_cnt;
      run_frame(1'b0, 18, -1, 12'h000, w);
      check("t2_word", {14'd0, w},          32'h00041);
      check("t2_type", {31'd0, frame_type}, 32'd0);
      check("t2_done", done_cnt - d0,       32'd1);
      check("t2_cnt",  {16'd0, frame_cnt},  32'd2);

      // 4: abort after 7 rises, then a full frame
      pos_in = 12'hABC; stat_in = 5'b10000; d0 = done_cnt; a0 = abort_cnt;
      run_frame(1'b1, 7, -1, 12'h000, w);
      check("t4_partial", {14'd0, w},             32'h00055);
      check("t4_abort",   abort_cnt - a0,         32'd1);
      check("t4_nodone",  done_cnt - d0,          32'd0);
      check("t4_cnt",     {16'd0, frame_cnt},     32'd2);
      check("t4_do",      {31'd0, ssi_if.ssi_do}, 32'd1);
      run_frame(1'b1, 18, -1, 12'h000, w);
      check("t4_next_word", {14'd0, w},         32'h2AF20);
      check("t4_next_cnt",  {16'd0, frame_cnt}, 32'd3);

      // 5: pos_in changes mid-frame; snapshot holds
      pos_in = 12'h123; stat_in = 5'b00000;
      run_frame(1'b1, 18, 5, 12'h456, w);
      check("t5_word_a", {14'd0, w}, 32'h048C0);
      run_frame(1'b1, 18, -1, 12'h000, w);
      check("t5_word_b", {14'd0, w}, 32'h11581);
      check("t5_cnt",    {16'd0, frame_cnt}, 32'd5);

      // 6: reset at bit 9 with CS held low
      pos_in = 12'hABC; stat_in = 5'b10000; d0 = done_cnt; a0 = abort_cnt;
      ssi_if.ssi_clk = 1'b1; wait_clk(H);
      ssi_if.ssi_cs = 1'b0;  wait_clk(H);
      ssi_if.ssi_clk = 1'b0; wait_clk(H);
      for (int k = 0; k < 9; k++) begin
         ssi_if.ssi_clk = 1'b1; wait_clk(H);
         ssi_if.ssi_clk = 1'b0; wait_clk(H);
      end
      rst_n = 1'b0;
      wait_clk(2);
      check("t6_rst_do",  {31'd0, ssi_if.ssi_do}, 32'd1);
      check("t6_rst_cnt", {16'd0, frame_cnt},     32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ssi_if.ssi_clk = 1'b1; wait_clk(H);
         check("t6_held_do", {31'd0, ssi_if.ssi_do}, 32'd1);
         ssi_if.ssi_clk = 1'b0; wait_clk(H);
      end
      ssi_if.ssi_clk = 1'b1; wait_clk(H);
      ssi_if.ssi_cs  = 1'b1; wait_clk(H);
      check("t6_no_pulse", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
      check("t6_idle_do",  {31'd0, ssi_if.ssi_do}, 32'd1);
      run_frame(1'b1, 18, -1, 12'h000, w);
      check("t6_word", {14'd0, w},         32'h2AF20);
      check("t6_cnt",  {16'd0, frame_cnt}, 32'd1);

      // 7: counter wrap
      @(negedge clk);
      force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
      wait_clk(2);
      check("t7_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
      run_frame(1'b1, 18, -1, 12'h000, w);
      check("t7_wrap", {16'd0, frame_cnt}, 32'd0);
      check("t7_word", {14'd0, w},         32'h2AF20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
